// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader and the core memory datapath.
package boot_loader_pkg;

  localparam int         MEM_ADDR_W    = 6;
  localparam int         MEM_DATA_W    = 16;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    WR,
    CSUM,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/boot_loader_byte_to_word.sv
// Assembles hi/lo bytes into a memory word and keeps the running XOR checksum.
module byte_to_word
  import boot_loader_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              ld_hi_i,
  input  logic              ld_lo_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic [7:0]        csum_o
);

  logic [DATA_W-1:0] word_q, word_d;
  logic [7:0]        csum_q, csum_d;

  always_comb begin
    word_d = word_q;
    csum_d = csum_q;
    if (clr_i) begin
      word_d = '0;
      csum_d = '0;
    end else if (ld_hi_i) begin
      word_d[DATA_W-1 -: 8] = byte_i;
      csum_d                = csum_q ^ byte_i;
    end else if (ld_lo_i) begin
      word_d[7:0] = byte_i;
      csum_d      = csum_q ^ byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      csum_q <= '0;
    end else begin
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end

  assign word_o = word_q;
  assign csum_o = csum_q;

endmodule

// File: rtl/boot_loader.sv
// Byte-stream boot loader: parses SYNC/LEN/data/CSUM frames, writes words into
// core memory and releases the core after a frame with a matching checksum.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int                ADDR_W    = MEM_ADDR_W,
  parameter int                DATA_W    = MEM_DATA_W,
  parameter logic [7:0]        SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr,
  output logic              core_run,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned     MAX_LEN  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] WC_ONE   = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              xfer, len_ok;
  logic              b2w_clr, b2w_hi, b2w_lo;
  logic [7:0]        csum;

  assign xfer   = byte_valid && byte_ready;
  assign len_ok = (byte_in != 8'd0) && (32'(byte_in) <= MAX_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (xfer && byte_in == SYNC_BYTE) state_d = LEN;
      LEN:  if (xfer) state_d = len_ok ? HI : ERR;
      HI:   if (xfer) state_d = LO;
      LO:   if (xfer) state_d = WR;
      WR:   state_d = (wc_q + WC_ONE == len_q) ? CSUM : HI;
      CSUM: if (xfer) state_d = (byte_in == csum) ? DONE : ERR;
      DONE: state_d = DONE;
      ERR:  if (xfer && byte_in == SYNC_BYTE) state_d = LEN;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a pure decode of the state register.
  always_comb begin
    byte_ready = 1'b0;
    mem_wr     = 1'b0;
    load_done  = 1'b0;
    core_run   = 1'b0;
    load_err   = 1'b0;
    unique case (state_q)
      IDLE, LEN, HI, LO, CSUM: byte_ready = 1'b1;
      WR: mem_wr = 1'b1;
      DONE: begin
        load_done = 1'b1;
        core_run  = 1'b1;
      end
      ERR: begin
        byte_ready = 1'b1;
        load_err   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    wc_d   = wc_q;
    len_d  = len_q;
    if (state_q == LEN && xfer && len_ok) begin
      addr_d = BASE_ADDR;
      wc_d   = '0;
      len_d  = byte_in[ADDR_W:0];
    end else if (state_q == WR) begin
      addr_d = addr_q + ADDR_ONE;
      wc_d   = wc_q + WC_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= BASE_ADDR;
      wc_q   <= '0;
      len_q  <= '0;
    end else begin
      addr_q <= addr_d;
      wc_q   <= wc_d;
      len_q  <= len_d;
    end
  end

  assign b2w_clr = (state_q == LEN) && xfer;
  assign b2w_hi  = (state_q == HI)  && xfer;
  assign b2w_lo  = (state_q == LO)  && xfer;

  byte_to_word #(.DATA_W(DATA_W)) u_b2w (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (b2w_clr),
    .ld_hi_i (b2w_hi),
    .ld_lo_i (b2w_lo),
    .byte_i  (byte_in),
    .word_o  (mem_data),
    .csum_o  (csum)
  );

  assign mem_addr   = addr_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized frame-level bench for boot_loader with a frame-composition reference model.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mem_wr, core_run, load_done, load_err;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data;
  logic [6:0]  word_count;

  int total = 0;
  int bad   = 0;
  int wr_ready_viol = 0;
  int both_viol     = 0;
  logic [5:0]  wa[$];
  logic [15:0] wd[$];

  always #5 clk = ~clk;

  boot_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wr     (mem_wr),
    .core_run   (core_run),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  // Write-port monitor: logs every strobe, including any during reset.
  always @(negedge clk) begin
    if (mem_wr) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
      if (byte_ready) wr_ready_viol++;
    end
    if (load_done && load_err) both_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called and returns at posedge+1; idle cycles carry random junk on byte_in.
  task automatic send(input logic [7:0] b, input int gapmax);
    int n;
    int g;
    g = $urandom_range(0, gapmax);
    byte_valid = 1'b0;
    repeat (g) begin
      byte_in = 8'($urandom);
      @(posedge clk); #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("ready_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wa.delete();
    wd.delete();
  endtask

  task automatic chk_status(input string tag, input bit done, input bit err);
    chk({tag, "_done"},  32'(load_done),  32'(done));
    chk({tag, "_run"},   32'(core_run),   32'(done));
    chk({tag, "_err"},   32'(load_err),   32'(err));
    chk({tag, "_ready"}, 32'(byte_ready), 32'(!done));
  endtask

  // Builds a frame of random words; expected writes and outcome follow from the frame contents.
  task automatic run_frame(input string tag, input int len, input bit corrupt, input int gapmax);
    logic [15:0] w[$];
    logic [7:0]  cs;
    logic [15:0] v;
    cs = 8'h00;
    wa.delete();
    wd.delete();
    send(8'hA5, gapmax);
    send(len[7:0], gapmax);
    for (int i = 0; i < len; i++) begin
      v = 16'($urandom);
      w.push_back(v);
      cs = cs ^ v[15:8] ^ v[7:0];
      send(v[15:8], gapmax);
      send(v[7:0], gapmax);
    end
    if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
    send(cs, gapmax);
    chk({tag, "_nwr"}, 32'(wa.size()), 32'(len));
    for (int i = 0; i < len && i < wa.size(); i++) begin
      chk($sformatf("%s_a%0d", tag, i), 32'(wa[i]), 32'(i % 64));
      chk($sformatf("%s_d%0d", tag, i), 32'(wd[i]), 32'(w[i]));
    end
    chk_status(tag, !corrupt, corrupt);
    chk({tag, "_wc"},   32'(word_count), 32'(len));
    chk({tag, "_addr"}, 32'(mem_addr),   32'(len % 64));
  endtask

  initial begin
    logic [7:0] bc[$];
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(byte_ready), 32'd1);
    chk("rst_outs",  32'({mem_wr, core_run, load_done, load_err}), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_wc",    32'(word_count), 32'd0);
    rst_n = 1'b1;

    // Reset asserted while the loader waits for the lo byte.
    send(8'hA5, 0); send(8'h01, 0); send(8'h12, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ready", 32'(byte_ready), 32'd1);
    chk("mid_outs",  32'({mem_wr, core_run, load_done, load_err}), 32'd0);
    chk("mid_addr",  32'(mem_addr), 32'd0);
    chk("mid_wc",    32'(word_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_nwr", 32'(wa.size()), 32'd0);
    run_frame("after_rst", 3, 1'b0, 1);

    do_reset();
    bc = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h26};
    foreach (bc[i]) send(bc[i], 1);
    chk("one_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() > 0) begin
      chk("one_addr", 32'(wa[0]), 32'd0);
      chk("one_data", 32'(wd[0]), 32'h1234);
    end
    chk_status("one", 1'b1, 1'b0);

    do_reset();
    bc = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFF};
    foreach (bc[i]) send(bc[i], 1);
    chk("bad_nwr", 32'(wa.size()), 32'd2);
    if (wa.size() > 1) begin
      chk("bad_w0", 32'({wa[0], wd[0]}), 32'({6'd0, 16'h0001}));
      chk("bad_w1", 32'({wa[1], wd[1]}), 32'({6'd1, 16'h0002}));
    end
    chk_status("bad", 1'b0, 1'b1);
    run_frame("recover", 5, 1'b0, 2);

    do_reset();
    send(8'hA5, 0); send(8'h00, 0);
    chk("len0_err", 32'(load_err), 32'd1);
    chk("len0_nwr", 32'(wa.size()), 32'd0);
    send(8'hA5, 0); send(8'h41, 0);
    chk("len65_err", 32'(load_err), 32'd1);
    chk("len65_nwr", 32'(wa.size()), 32'd0);
    chk("len65_run", 32'(core_run), 32'd0);

    do_reset();
    send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
    chk("junk_nwr", 32'(wa.size()), 32'd0);
    run_frame("full64", 64, 1'b0, 3);

    for (int k = 0; k < 6; k++) begin
      do_reset();
      run_frame($sformatf("rnd%0d", k), $urandom_range(1, 20), 1'($urandom_range(0, 1)), 2);
    end

    chk("wr_while_ready", 32'(wr_ready_viol), 32'd0);
    chk("done_err_excl",  32'(both_viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
